bcd_updown_timer: RTL and testbench

BCD_UPDOWN_TIMER -- requirements
Module: bcd_updown_timer

---
 rtl/bcd_updown_timer_pkg.sv | 13 +
 rtl/bcd_updown_timer_if.sv | 23 ++
 rtl/bcd_updown_timer_digit.sv | 33 +++
 rtl/bcd_updown_timer.sv | 109 ++++++++++
 tb/tb_bcd_updown_timer.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/bcd_updown_timer_pkg.sv
// Shared constants, FSM state type and digit helper for the BCD up/down timer.
`timescale 1ns/1ps
package timer_pkg;
  localparam int          DIGIT_W = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Non-decimal nibbles (A..F) are clamped to 9.
  function automatic logic [DIGIT_W-1:0] bcd_sat(input logic [DIGIT_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction
endpackage

// File: rtl/bcd_updown_timer_if.sv
// Control/status bundle of the BCD up/down timer; master drives controls, slave is the timer.
`timescale 1ns/1ps
interface bcd_updown_timer_if #(parameter int NUM_DIGITS = 5);
  logic                    en_i;
  logic                    up_i;
  logic                    load_i;
  logic [4*NUM_DIGITS-1:0] load_val_i;
  logic                    wrap_i;
  logic [4*NUM_DIGITS-1:0] count_o;
  logic                    tick_o;
  logic                    done_o;
  logic                    running_o;

  modport master (
    output en_i, up_i, load_i, load_val_i, wrap_i,
    input  count_o, tick_o, done_o, running_o
  );

  modport slave (
    input  en_i, up_i, load_i, load_val_i, wrap_i,
    output count_o, tick_o, done_o, running_o
  );
endinterface

// File: rtl/bcd_updown_timer_digit.sv
// One combinational BCD digit: next value plus carry (up) or borrow (down) out.
`timescale 1ns/1ps
module bcd_digit
  import timer_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  input  logic               up_i,
  input  logic               step_i,
  output logic [DIGIT_W-1:0] digit_o,
  output logic               carry_o
);
  always_comb begin
    digit_o = digit_i;
    carry_o = 1'b0;
    if (step_i) begin
      if (up_i) begin
        if (digit_i >= BCD_MAX) begin
          digit_o = '0;
          carry_o = 1'b1;
        end else begin
          digit_o = digit_i + 4'd1;
        end
      end else begin
        if (digit_i == '0) begin
          digit_o = BCD_MAX;
          carry_o = 1'b1;
        end else begin
          digit_o = digit_i - 4'd1;
        end
      end
    end
  end
endmodule

// File: rtl/bcd_updown_timer.sv
// Prescaled BCD up/down counter with wrap-or-stop terminal handling and IDLE/RUN/DONE control.
`timescale 1ns/1ps
module bcd_updown_timer
  import timer_pkg::*;
#(
  parameter int NUM_DIGITS = 5,
  parameter int TICK_DIV   = 6250000,
  parameter int PRE_BITS   = 26
) (
  input  logic               clk,
  input  logic               rst,
  bcd_updown_timer_if.slave  bus
);
  localparam int                W        = DIGIT_W * NUM_DIGITS;
  localparam logic [PRE_BITS-1:0] PRE_LAST = PRE_BITS'(TICK_DIV - 1);

  state_t              state_q, state_d;
  logic [W-1:0]        count_q, count_d;
  logic [PRE_BITS-1:0] pre_q, pre_d;
  logic                tick_q, tick_d;
  logic                done_q, done_d;

  logic [W-1:0]        next_cnt;
  logic [W-1:0]        load_sat;
  logic [NUM_DIGITS:0] carry;
  logic                terminal;
  logic                step_due;
  logic                stop_hit;

  // The chain is always stepped; a carry/borrow out of the top digit means every digit was at its terminal value.
  assign carry[0] = 1'b1;
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .digit_i (count_q[g*DIGIT_W +: DIGIT_W]),
      .up_i    (bus.up_i),
      .step_i  (carry[g]),
      .digit_o (next_cnt[g*DIGIT_W +: DIGIT_W]),
      .carry_o (carry[g+1])
    );
  end

  always_comb begin
    load_sat = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      load_sat[i*DIGIT_W +: DIGIT_W] = bcd_sat(bus.load_val_i[i*DIGIT_W +: DIGIT_W]);
    end
  end

  assign terminal = carry[NUM_DIGITS];
  assign step_due = (state_q == RUN) && bus.en_i && (pre_q == PRE_LAST);
  assign stop_hit = terminal && !bus.wrap_i;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pre_d   = pre_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;

    // A load overrides any step due in the same cycle.
    if (bus.load_i) begin
      count_d = load_sat;
      pre_d   = '0;
    end else if (step_due) begin
      pre_d  = '0;
      done_d = terminal;
      if (!stop_hit) begin
        count_d = next_cnt;
        tick_d  = 1'b1;
      end
    end else if ((state_q == RUN) && bus.en_i) begin
      pre_d = pre_q + PRE_BITS'(1);
    end

    case (state_q)
      IDLE: if (bus.en_i) state_d = RUN;
      RUN: begin
        if (!bus.en_i)                               state_d = IDLE;
        else if (!bus.load_i && step_due && stop_hit) state_d = DONE;
      end
      DONE: begin
        if (bus.load_i)   state_d = bus.en_i ? RUN : IDLE;
        else if (!bus.en_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      pre_q   <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  assign bus.count_o   = count_q;
  assign bus.tick_o    = tick_q;
  assign bus.done_o    = done_q;
  assign bus.running_o = (state_q == RUN);
endmodule

// File: tb/tb_bcd_updown_timer.sv
// Directed bench for bcd_updown_timer with NUM_DIGITS=2, TICK_DIV=4: vector table plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_bcd_updown_timer;
  import timer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  bcd_updown_timer_if #(.NUM_DIGITS(2)) bus ();

  bcd_updown_timer #(
    .NUM_DIGITS (2),
    .TICK_DIV   (4),
    .PRE_BITS   (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       load;
    logic [7:0] val;
    logic       en;
    logic       up;
    logic       wrap;
    logic [7:0] count;
    logic       tick;
    logic       done;
    logic       run;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic ld, input logic [7:0] v, input logic e, input logic u,
                              input logic w, input logic [7:0] c, input logic t, input logic d,
                              input logic r);
    vec_t x;
    x.load = ld; x.val = v; x.en = e; x.up = u; x.wrap = w;
    x.count = c; x.tick = t; x.done = d; x.run = r;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic chk_out(input string name, input logic [7:0] c, input logic t, input logic d,
                         input logic r);
    chk({name, ".count"},   32'(bus.count_o),   32'(c));
    chk({name, ".tick"},    32'(bus.tick_o),    32'(t));
    chk({name, ".done"},    32'(bus.done_o),    32'(d));
    chk({name, ".running"}, 32'(bus.running_o), 32'(r));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Count up 19 -> 20 on the 4th edge after entering RUN.
    tbl.push_back(mk(1, 8'h19, 1, 1, 0, 8'h19, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h19, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h19, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h19, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h20, 1, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h20, 0, 0, 1));
    // Wrap up 99 -> 00 with tick and done together, staying in RUN.
    tbl.push_back(mk(1, 8'h99, 1, 1, 1, 8'h99, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 1, 1, 8'h99, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 1, 1, 8'h99, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 1, 1, 8'h99, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 1, 1, 8'h00, 1, 1, 1));
    tbl.push_back(mk(0, 8'h00, 1, 1, 1, 8'h00, 0, 0, 1));
    // Load colliding with a due step wins; A5 is clamped to 95.
    tbl.push_back(mk(1, 8'h50, 1, 1, 0, 8'h50, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h50, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h50, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h50, 0, 0, 1));
    tbl.push_back(mk(1, 8'hA5, 1, 1, 0, 8'h95, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h95, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h95, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h95, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h96, 1, 0, 1));
    // Count down 01 -> 00, then stop at 00 without wrap.
    tbl.push_back(mk(1, 8'h01, 1, 0, 0, 8'h01, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 8'h01, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 8'h01, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 8'h01, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 1, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 0));

    // Reset held with enable high: nothing may move.
    rst = 1'b0;
    bus.en_i = 1'b1; bus.up_i = 1'b1; bus.load_i = 1'b1; bus.load_val_i = 8'h42; bus.wrap_i = 1'b1;
    repeat (3) cyc();
    chk_out("reset", 8'h00, 0, 0, 0);
    bus.en_i = 1'b0; bus.load_i = 1'b0; bus.load_val_i = 8'h00;
    #2 rst = 1'b1;
    cyc();
    chk_out("post_reset_idle", 8'h00, 0, 0, 0);

    foreach (tbl[i]) begin
      bus.load_i = tbl[i].load; bus.load_val_i = tbl[i].val;
      bus.en_i = tbl[i].en; bus.up_i = tbl[i].up; bus.wrap_i = tbl[i].wrap;
      cyc();
      chk_out($sformatf("vec%0d", i), tbl[i].count, tbl[i].tick, tbl[i].done, tbl[i].run);
    end

    // In DONE: flipping direction must not restart counting.
    bus.up_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      chk_out($sformatf("done_hold%0d", k), 8'h00, 0, 0, 0);
    end

    // Load out of DONE with enable high returns to RUN.
    bus.load_i = 1'b1; bus.load_val_i = 8'h05;
    cyc();
    chk_out("done_reload", 8'h05, 0, 0, 1);
    bus.load_i = 1'b0;
    cyc(); cyc();
    chk_out("pre_at_2", 8'h05, 0, 0, 1);

    // Pause with prescaler at 2; count must not move.
    bus.en_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk_out($sformatf("pause%0d", k), 8'h05, 0, 0, 0);
    end
    // Resume: one edge to re-enter RUN, then prescaler 2->3, then the step.
    bus.en_i = 1'b1;
    cyc();
    chk_out("resume0", 8'h05, 0, 0, 1);
    cyc();
    chk_out("resume1", 8'h05, 0, 0, 1);
    cyc();
    chk_out("resume_tick", 8'h06, 1, 0, 1);

    // Asynchronous reset between edges.
    #3 rst = 1'b0;
    #1 chk_out("async_reset", 8'h00, 0, 0, 0);
    bus.en_i = 1'b0;
    #2 rst = 1'b1;
    repeat (3) cyc();
    chk_out("idle_after_reset", 8'h00, 0, 0, 0);
    bus.en_i = 1'b1;
    cyc();
    chk_out("first_en_edge", 8'h00, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
